ddr3_app_arbiter: RTL and testbench



---
 rtl/ddr3_app_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_ddr3_app_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter
// Two-requester round-robin arbiter in front of a single DDR3 controller
// user interface. One single-beat command is in flight on the app_* side at
// a time; read returns are steered back to the issuing requester through an
// in-order tag FIFO that records which requester issued each read.
module ddr3_app_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = 8,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,

    input  logic                  rq0_valid,
    output logic                  rq0_ready,
    input  logic [2:0]            rq0_cmd,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_wdata,
    input  logic [MASK_WIDTH-1:0] rq0_wmask,

    input  logic                  rq1_valid,
    output logic                  rq1_ready,
    input  logic [2:0]            rq1_cmd,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_wdata,
    input  logic [MASK_WIDTH-1:0] rq1_wmask,

    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,

    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    input  logic                  app_rdy,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic [MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                  app_wdf_rdy,
    input  logic                  app_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] app_rd_data,

    output logic                  rd_orphan
);

    localparam int              PTR_W    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] TAG_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [2:0]      CMD_WR   = 3'b000;
    localparam logic [2:0]      CMD_RD   = 3'b001;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q;
    logic                    cmd_done_q, data_done_q;

    // Captured request being issued
    logic                    iss_id_q;
    logic                    iss_rd_q;
    logic [ADDR_WIDTH-1:0]   iss_addr_q;
    logic [DATA_WIDTH-1:0]   iss_wdata_q;
    logic [MASK_WIDTH-1:0]   iss_wmask_q;

    // Tag FIFO: one bit per outstanding read, holding the issuing requester id
    logic                    tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]        tag_wr_ptr_q, tag_rd_ptr_q;
    logic [CNT_W-1:0]        tag_cnt_q;
    logic                    tag_full, tag_empty, tag_push, tag_pop, tag_head;

    logic                    elig0, elig1;
    logic                    accept, grant_id, acc_rd;
    logic                    cmd_hs, data_hs;

    assign tag_full  = (tag_cnt_q == TAG_FULL);
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_head  = tag_mem[tag_rd_ptr_q];
    assign tag_push  = cmd_hs & iss_rd_q;
    assign tag_pop   = app_rd_data_valid & ~tag_empty;

    // Anything that is not a write travels as a read and needs a free tag.
    assign elig0 = rst_n & rq0_valid & init_calib_complete & ((rq0_cmd == CMD_WR) | ~tag_full);
    assign elig1 = rst_n & rq1_valid & init_calib_complete & ((rq1_cmd == CMD_WR) | ~tag_full);

    // Grant, handshakes, app_* drive and next state
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        grant_id     = 1'b0;
        acc_rd       = 1'b0;
        rq0_ready    = 1'b0;
        rq1_ready    = 1'b0;
        cmd_hs       = 1'b0;
        data_hs      = 1'b0;
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_addr     = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        case (state_q)
            IDLE: begin
                // Requester 0 wins a tie unless it was the last one served.
                if (elig0 && (!elig1 || last_grant_q)) begin
                    accept    = 1'b1;
                    grant_id  = 1'b0;
                    rq0_ready = 1'b1;
                    acc_rd    = (rq0_cmd != CMD_WR);
                end else if (elig1) begin
                    accept    = 1'b1;
                    grant_id  = 1'b1;
                    rq1_ready = 1'b1;
                    acc_rd    = (rq1_cmd != CMD_WR);
                end
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!cmd_done_q) begin
                    app_en   = 1'b1;
                    app_cmd  = iss_rd_q ? CMD_RD : CMD_WR;
                    app_addr = iss_addr_q;
                    cmd_hs   = app_rdy;
                end
                if (!data_done_q) begin
                    app_wdf_wren = 1'b1;
                    app_wdf_end  = 1'b1;
                    app_wdf_data = iss_wdata_q;
                    app_wdf_mask = iss_wmask_q;
                    data_hs      = app_wdf_rdy;
                end
                if ((cmd_done_q || cmd_hs) && (data_done_q || data_hs)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, round-robin pointer and per-command handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cmd_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant_id;
                cmd_done_q   <= 1'b0;
                data_done_q  <= acc_rd;
            end else begin
                if (cmd_hs) begin
                    cmd_done_q <= 1'b1;
                end
                if (data_hs) begin
                    data_done_q <= 1'b1;
                end
            end
        end
    end

    // Issue registers load the granted request's payload on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            iss_id_q    <= grant_id;
            iss_rd_q    <= acc_rd;
            iss_addr_q  <= grant_id ? rq1_addr  : rq0_addr;
            iss_wdata_q <= grant_id ? rq1_wdata : rq0_wdata;
            iss_wmask_q <= grant_id ? rq1_wmask : rq0_wmask;
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr_q <= tag_wr_ptr_q + 1'b1;
            end
            if (tag_pop) begin
                tag_rd_ptr_q <= tag_rd_ptr_q + 1'b1;
            end
            if (tag_push && !tag_pop) begin
                tag_cnt_q <= tag_cnt_q + 1'b1;
            end else if (tag_pop && !tag_push) begin
                tag_cnt_q <= tag_cnt_q - 1'b1;
            end
        end
    end

    // Tag FIFO storage
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr_q] <= iss_id_q;
        end
    end

    // Read return: steer one beat to the head-of-FIFO requester, flag orphans
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
            rd0_data  <= '0;
            rd1_data  <= '0;
            rd_orphan <= 1'b0;
        end else begin
            rd0_valid <= tag_pop & ~tag_head;
            rd1_valid <= tag_pop & tag_head;
            if (tag_pop && !tag_head) begin
                rd0_data <= app_rd_data;
            end
            if (tag_pop && tag_head) begin
                rd1_data <= app_rd_data;
            end
            if (app_rd_data_valid && tag_empty) begin
                rd_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Randomized bench for ddr3_app_arbiter against a transaction-level model:
// a pending-request record, a queue of outstanding read owners and the
// expected registered read-return outputs.
module tb_ddr3_app_arbiter;

    localparam int AW = 28;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int TD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_calib_complete;
    logic          rq0_valid, rq1_valid;
    logic          rq0_ready, rq1_ready;
    logic [2:0]    rq0_cmd, rq1_cmd;
    logic [AW-1:0] rq0_addr, rq1_addr;
    logic [DW-1:0] rq0_wdata, rq1_wdata;
    logic [MW-1:0] rq0_wmask, rq1_wmask;
    logic          rd0_valid, rd1_valid;
    logic [DW-1:0] rd0_data, rd1_data;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          app_wdf_wren, app_wdf_end;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_rdy;
    logic          app_rd_data_valid;
    logic [DW-1:0] app_rd_data;
    logic          rd_orphan;

    always #5 clk = ~clk;

    ddr3_app_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_cmd(rq0_cmd),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_wmask(rq0_wmask),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_cmd(rq1_cmd),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_wmask(rq1_wmask),
        .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data(app_rd_data), .rd_orphan(rd_orphan)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            busy, m_cmd_done, m_data_done, m_rd, m_id, last_g;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    bit            tagq[$];
    bit            exp_v0, exp_v1, exp_orphan;
    logic [DW-1:0] exp_d0, exp_d1;
    int            n_acc0, n_acc1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; m_cmd_done = 0; m_data_done = 0; m_rd = 0; m_id = 0;
        last_g = 1; tagq.delete();
        exp_v0 = 0; exp_v1 = 0; exp_orphan = 0; exp_d0 = '0; exp_d1 = '0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rq0_ready", rq0_ready, 0);
        check_eq("rst_rq1_ready", rq1_ready, 0);
        check_eq("rst_app_en", app_en, 0);
        check_eq("rst_app_cmd", app_cmd, 0);
        check_eq("rst_app_addr", app_addr, 0);
        check_eq("rst_wdf_wren", app_wdf_wren, 0);
        check_eq("rst_wdf_end", app_wdf_end, 0);
        check_eq("rst_wdf_data", app_wdf_data, 0);
        check_eq("rst_wdf_mask", app_wdf_mask, 0);
        check_eq("rst_rd0_valid", rd0_valid, 0);
        check_eq("rst_rd1_valid", rd1_valid, 0);
        check_eq("rst_rd0_data", rd0_data, 0);
        check_eq("rst_rd1_data", rd1_data, 0);
        check_eq("rst_rd_orphan", rd_orphan, 0);
    endtask

    // One clock: compare DUT to the model mid-cycle, advance the model, then
    // wait for the edge so the caller can drive the next inputs.
    task automatic step();
        bit e0, e1, acc, gid, e_en, e_wren, cmd_hs, data_hs, owner;
        @(negedge clk);
        e0 = rq0_valid && init_calib_complete && (rq0_cmd == 3'b000 || tagq.size() < TD);
        e1 = rq1_valid && init_calib_complete && (rq1_cmd == 3'b000 || tagq.size() < TD);
        acc = 0; gid = 0;
        if (!busy) begin
            if (e0 && (!e1 || last_g)) begin acc = 1; gid = 0; end
            else if (e1) begin acc = 1; gid = 1; end
        end
        e_en   = busy && !m_cmd_done;
        e_wren = busy && !m_data_done;
        check_eq("rq0_ready", rq0_ready, acc && !gid);
        check_eq("rq1_ready", rq1_ready, acc && gid);
        check_eq("app_en", app_en, e_en);
        if (e_en) begin
            check_eq("app_cmd", app_cmd, m_rd ? 3'b001 : 3'b000);
            check_eq("app_addr", app_addr, m_addr);
        end
        check_eq("app_wdf_wren", app_wdf_wren, e_wren);
        check_eq("app_wdf_end", app_wdf_end, e_wren);
        if (e_wren) begin
            check_eq("app_wdf_data", app_wdf_data, m_wdata);
            check_eq("app_wdf_mask", app_wdf_mask, m_wmask);
        end
        check_eq("rd0_valid", rd0_valid, exp_v0);
        check_eq("rd1_valid", rd1_valid, exp_v1);
        check_eq("rd0_data", rd0_data, exp_d0);
        check_eq("rd1_data", rd1_data, exp_d1);
        check_eq("rd_orphan", rd_orphan, exp_orphan);

        cmd_hs  = e_en && app_rdy;
        data_hs = e_wren && app_wdf_rdy;
        exp_v0 = 0; exp_v1 = 0;
        if (app_rd_data_valid) begin
            if (tagq.size() > 0) begin
                owner = tagq.pop_front();
                if (owner) begin exp_v1 = 1; exp_d1 = app_rd_data; end
                else       begin exp_v0 = 1; exp_d0 = app_rd_data; end
            end else begin
                exp_orphan = 1;
            end
        end
        if (cmd_hs && m_rd) tagq.push_back(m_id);
        if (busy) begin
            if (cmd_hs)  m_cmd_done  = 1;
            if (data_hs) m_data_done = 1;
            if (m_cmd_done && m_data_done) busy = 0;
        end else if (acc) begin
            busy        = 1;
            m_id        = gid;
            m_rd        = gid ? (rq1_cmd != 3'b000) : (rq0_cmd != 3'b000);
            m_addr      = gid ? rq1_addr  : rq0_addr;
            m_wdata     = gid ? rq1_wdata : rq0_wdata;
            m_wmask     = gid ? rq1_wmask : rq0_wmask;
            m_cmd_done  = 0;
            m_data_done = m_rd;
            last_g      = gid;
            if (gid) n_acc1++; else n_acc0++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pick_cmd(int prd);
        if ($urandom_range(99) < prd)
            return ($urandom_range(9) == 0) ? 3'($urandom_range(7, 2)) : 3'b001;
        return 3'b000;
    endfunction

    task automatic drive_rand(int pv, int prd, int pret, int prdy, bit any_ret);
        rq0_valid = ($urandom_range(99) < pv);
        rq1_valid = ($urandom_range(99) < pv);
        rq0_cmd   = pick_cmd(prd);
        rq1_cmd   = pick_cmd(prd);
        rq0_addr  = AW'($urandom);
        rq1_addr  = AW'($urandom);
        rq0_wdata = {$urandom, $urandom};
        rq1_wdata = {$urandom, $urandom};
        rq0_wmask = MW'($urandom);
        rq1_wmask = MW'($urandom);
        app_rdy     = ($urandom_range(99) < prdy);
        app_wdf_rdy = ($urandom_range(99) < prdy);
        app_rd_data_valid = ($urandom_range(99) < pret) && (any_ret || tagq.size() > 0);
        app_rd_data = {$urandom, $urandom};
        init_calib_complete = ($urandom_range(99) < 95);
    endtask

    task automatic run_phase(int n, int pv, int prd, int pret, int prdy, bit any_ret);
        for (int i = 0; i < n; i++) begin
            drive_rand(pv, prd, pret, prdy, any_ret);
            step();
        end
    endtask

    initial begin
        rst_n = 0; init_calib_complete = 0;
        rq0_valid = 0; rq1_valid = 0; rq0_cmd = 0; rq1_cmd = 0;
        rq0_addr = 0; rq1_addr = 0; rq0_wdata = 0; rq1_wdata = 0;
        rq0_wmask = 0; rq1_wmask = 0;
        app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = 0;
        n_acc0 = 0; n_acc1 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1;

        // Calibration not done: a pending write must not be accepted
        rq0_valid = 1; rq0_cmd = 3'b000; rq0_addr = 28'h0ABCDEF;
        rq0_wdata = 64'h0123_4567_89AB_CDEF; rq0_wmask = 8'h5A;
        app_rdy = 1; app_wdf_rdy = 1;
        repeat (4) step();
        init_calib_complete = 1;
        step();
        rq0_valid = 0;
        repeat (3) step();

        // Both requesters streaming writes with an always-ready controller
        rq0_valid = 1; rq1_valid = 1; rq1_cmd = 3'b000;
        for (int i = 0; i < 12; i++) begin
            rq0_addr = AW'(i); rq1_addr = AW'(i + 100);
            step();
        end
        check_eq("alternating_grants", n_acc1, n_acc0 - 1);
        rq0_valid = 0; rq1_valid = 0;

        // Write whose command handshake trails its data handshake
        rq0_valid = 1; app_rdy = 0; app_wdf_rdy = 1;
        step();
        rq0_valid = 0;
        repeat (3) step();
        app_rdy = 1;
        repeat (3) step();

        run_phase(400, 70, 50, 40, 70, 0);
        run_phase(400, 80, 90, 5, 80, 0);
        run_phase(300, 90, 10, 60, 100, 0);
        run_phase(200, 60, 50, 50, 30, 1);

        // Drain outstanding reads, then return data nobody asked for
        rq0_valid = 0; rq1_valid = 0; app_rdy = 1; app_wdf_rdy = 1;
        init_calib_complete = 1;
        for (int i = 0; i < 2 * TD + 6; i++) begin
            app_rd_data_valid = (tagq.size() > 0);
            app_rd_data = {$urandom, $urandom};
            step();
        end
        app_rd_data_valid = 1; app_rd_data = 64'hDEAD_BEEF_0000_0001;
        step();
        app_rd_data_valid = 0;
        step();
        check_eq("orphan_set", rd_orphan, 1);

        // Reset while a read sits in ISSUE with the controller stalled
        rq0_valid = 1; rq0_cmd = 3'b001; rq0_addr = 28'h1234567;
        app_rdy = 0; app_wdf_rdy = 0;
        step();
        step();
        rst_n = 0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rq0_valid = 0; app_rdy = 1; app_wdf_rdy = 1;
        rst_n = 1;
        step();
        app_rd_data_valid = 1; app_rd_data = 64'h5555_AAAA_5555_AAAA;
        step();
        app_rd_data_valid = 0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
